// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad door-lock controller.
// Collects a DIGITS-long code, compares it to the stored code, and opens the lock
// for OPEN_CYCLES clocks. A code-change mode (SET) is reachable only from OPEN.
// Build option: define DOORLOCK_LOCKOUT_EN to enable the timed lockout after
// MAX_TRIES consecutive wrong codes. Without it, wrong codes only bump a
// saturating try counter.
module doorlock_ctrl #(
   parameter int DIGITS      = 4,
   parameter int DIGIT_W     = 4,
   parameter int MAX_TRIES   = 3,
   parameter int OPEN_CYCLES = 500,
   parameter int LOCK_CYCLES = 1000
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [1:0]                         mode_i,
   input  logic                               key_valid_i,
   input  logic [DIGIT_W-1:0]                 key_i,
   input  logic                               set_i,
   output logic [2:0]                         state_o,
   output logic [2:0]                         led_sig_o,
   output logic                               unlock_o,
   output logic                               alarm_o,
   output logic [$clog2(MAX_TRIES+1)-1:0]     tries_o
);

   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int CNT_W  = $clog2(DIGITS + 1);
   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int OT_W   = $clog2(OPEN_CYCLES + 1);

   localparam logic [1:0] CMD_A   = 2'd1;
   localparam logic [1:0] CMD_B   = 2'd2;
   localparam logic [1:0] CMD_CLR = 2'd3;

   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DIGITS);
   localparam logic [TRY_W:0]   MAX_T     = (TRY_W + 1)'(MAX_TRIES);
   localparam logic [OT_W-1:0]  OPEN_LOAD = OT_W'(OPEN_CYCLES);

`ifdef DOORLOCK_LOCKOUT_EN
   localparam int               LT_W      = $clog2(LOCK_CYCLES + 1);
   localparam logic [LT_W-1:0]  LOCK_LOAD = LT_W'(LOCK_CYCLES);
`endif

   // Reject illegal configurations at elaboration time.
   generate
      if (DIGITS < 1 || DIGIT_W < 1 || MAX_TRIES < 1 || OPEN_CYCLES < 2 || LOCK_CYCLES < 2)
      begin : g_bad_param
         $error("doorlock_ctrl: illegal parameter value");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ENT  = 3'd1,
      ST_SET  = 3'd2,
      ST_OPEN = 3'd3,
      ST_LOCK = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   code_q,  code_d;
   logic [CODE_W-1:0]   dbuf_q,  dbuf_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [TRY_W-1:0]    tries_q, tries_d;
   logic [OT_W-1:0]     otmr_q,  otmr_d;
`ifdef DOORLOCK_LOCKOUT_EN
   logic [LT_W-1:0]     ltmr_q,  ltmr_d;
`endif

   logic [CODE_W-1:0]   code_in;
   logic [CNT_W-1:0]    cnt_inc;
   logic [TRY_W:0]      tries_inc;
   logic                last_key;
   logic                cnt_full;

   // Datapath helpers: buffer with the current key shifted in (first digit ends up MSB).
   always_comb begin
      code_in   = (dbuf_q << DIGIT_W) | CODE_W'(key_i);
      cnt_inc   = cnt_q + 1'b1;
      tries_inc = {1'b0, tries_q} + 1'b1;
      last_key  = (cnt_inc == CNT_FULL);
      cnt_full  = (cnt_q == CNT_FULL);
   end

   // Next-state and register-update logic for the lock FSM.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      dbuf_d  = dbuf_q;
      cnt_d   = cnt_q;
      tries_d = tries_q;
      otmr_d  = otmr_q;
`ifdef DOORLOCK_LOCKOUT_EN
      ltmr_d  = ltmr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (mode_i == CMD_A) begin
               state_d = ST_ENT;
               cnt_d   = '0;
            end
         end
         ST_ENT: begin
            // CLR wins over a key strobe in the same cycle.
            if (mode_i == CMD_CLR) begin
               cnt_d = '0;
            end else if (key_valid_i) begin
               dbuf_d = code_in;
               if (!last_key) begin
                  cnt_d = cnt_inc;
               end else begin
                  cnt_d = '0;
                  if (code_in == code_q) begin
                     state_d = ST_OPEN;
                     tries_d = '0;
                     otmr_d  = OPEN_LOAD;
                  end
`ifdef DOORLOCK_LOCKOUT_EN
                  else if (tries_inc >= MAX_T) begin
                     state_d = ST_LOCK;
                     tries_d = MAX_T[TRY_W-1:0];
                     ltmr_d  = LOCK_LOAD;
                  end else begin
                     tries_d = tries_inc[TRY_W-1:0];
                  end
`else
                  else if (tries_inc <= MAX_T) begin
                     tries_d = tries_inc[TRY_W-1:0];
                  end
`endif
               end
            end
         end
         ST_OPEN: begin
            // Explicit commands take priority over timer expiry.
            if (mode_i == CMD_A) begin
               state_d = ST_IDLE;
            end else if (mode_i == CMD_B) begin
               state_d = ST_SET;
               cnt_d   = '0;
            end else if (otmr_q <= OT_W'(1)) begin
               state_d = ST_IDLE;
               otmr_d  = '0;
            end else begin
               otmr_d = otmr_q - 1'b1;
            end
         end
         ST_SET: begin
            if (set_i) begin
               cnt_d = '0;
               if (cnt_full) begin
                  code_d  = dbuf_q;
                  state_d = ST_IDLE;
               end else begin
                  // Incomplete new code is dropped; back to OPEN with a full timer.
                  state_d = ST_OPEN;
                  otmr_d  = OPEN_LOAD;
               end
            end else if (mode_i == CMD_CLR) begin
               cnt_d = '0;
            end else if (key_valid_i && !cnt_full) begin
               dbuf_d = code_in;
               cnt_d  = cnt_inc;
            end
         end
`ifdef DOORLOCK_LOCKOUT_EN
         ST_LOCK: begin
            if (ltmr_q <= LT_W'(1)) begin
               state_d = ST_IDLE;
               tries_d = '0;
               ltmr_d  = '0;
            end else begin
               ltmr_d = ltmr_q - 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         dbuf_q  <= '0;
         cnt_q   <= '0;
         tries_q <= '0;
         otmr_q  <= '0;
`ifdef DOORLOCK_LOCKOUT_EN
         ltmr_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         dbuf_q  <= dbuf_d;
         cnt_q   <= cnt_d;
         tries_q <= tries_d;
         otmr_q  <= otmr_d;
`ifdef DOORLOCK_LOCKOUT_EN
         ltmr_q  <= ltmr_d;
`endif
      end
   end

   // Output decode of the state register.
   always_comb begin
      led_sig_o = 3'd3;
      unlock_o  = 1'b0;
      alarm_o   = 1'b0;
      case (state_q)
         ST_ENT:  led_sig_o = 3'd0;
         ST_SET:  led_sig_o = 3'd2;
         ST_OPEN: begin
            led_sig_o = 3'd1;
            unlock_o  = 1'b1;
         end
`ifdef DOORLOCK_LOCKOUT_EN
         ST_LOCK: begin
            led_sig_o = 3'd4;
            alarm_o   = 1'b1;
         end
`endif
         default: led_sig_o = 3'd3;
      endcase
   end

   assign state_o = state_q;
   assign tries_o = tries_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_doorlock_ctrl;
   localparam int DIGITS      = 4;
   localparam int DIGIT_W     = 4;
   localparam int MAX_TRIES   = 3;
   localparam int OPEN_CYCLES = 8;
   localparam int LOCK_CYCLES = 16;
`ifdef DOORLOCK_LOCKOUT_EN
   localparam bit LOCKOUT = 1'b1;
`else
   localparam bit LOCKOUT = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [1:0]         mode = 2'd0;
   logic               kv = 1'b0;
   logic [DIGIT_W-1:0] key = '0;
   logic               set = 1'b0;
   logic [2:0]         state_o, led_o;
   logic               unlock_o, alarm_o;
   logic [1:0]         tries_o;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   doorlock_ctrl #(
      .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES),
      .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .key_valid_i(kv), .key_i(key),
      .set_i(set), .state_o(state_o), .led_sig_o(led_o), .unlock_o(unlock_o),
      .alarm_o(alarm_o), .tries_o(tries_o)
   );

   // ---------------- behavioural model ----------------
   // Modes: 0 idle, 1 entering, 2 setting, 3 open, 4 lockout (numbers are the
   // visible state_o values). Digits typed so far live in a queue.
   int m_st, m_tries, m_left;
   int m_code[DIGITS];
   int m_dig[$];

   function automatic int led_of(int s);
      case (s)
         1: return 0;
         2: return 2;
         3: return 1;
         4: return 4;
         default: return 3;
      endcase
   endfunction

   function automatic void model_reset();
      m_st = 0; m_tries = 0; m_left = 0;
      foreach (m_code[i]) m_code[i] = 0;
      m_dig.delete();
   endfunction

   function automatic void model_step(int md, bit k, int kd, bit s);
      bit match;
      case (m_st)
         0: if (md == 1) begin m_st = 1; m_dig.delete(); end
         1: begin
            if (md == 3) m_dig.delete();
            else if (k) begin
               m_dig.push_back(kd);
               if (m_dig.size() == DIGITS) begin
                  match = 1'b1;
                  for (int i = 0; i < DIGITS; i++) if (m_dig[i] != m_code[i]) match = 1'b0;
                  m_dig.delete();
                  if (match) begin m_st = 3; m_tries = 0; m_left = OPEN_CYCLES; end
                  else if (LOCKOUT && m_tries + 1 >= MAX_TRIES) begin
                     m_st = 4; m_tries = MAX_TRIES; m_left = LOCK_CYCLES;
                  end else if (m_tries < MAX_TRIES) m_tries++;
               end
            end
         end
         3: begin
            if (md == 1) m_st = 0;
            else if (md == 2) begin m_st = 2; m_dig.delete(); end
            else begin
               m_left--;
               if (m_left == 0) m_st = 0;
            end
         end
         2: begin
            if (s) begin
               if (m_dig.size() == DIGITS) begin
                  for (int i = 0; i < DIGITS; i++) m_code[i] = m_dig[i];
                  m_st = 0;
               end else begin
                  m_st = 3; m_left = OPEN_CYCLES;
               end
               m_dig.delete();
            end else if (md == 3) m_dig.delete();
            else if (k && m_dig.size() < DIGITS) m_dig.push_back(kd);
         end
         4: begin
            m_left--;
            if (m_left == 0) begin m_st = 0; m_tries = 0; end
         end
         default: m_st = 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_state",  32'(state_o),  32'(m_st));
         chk("m_led",    32'(led_o),    32'(led_of(m_st)));
         chk("m_unlock", 32'(unlock_o), 32'(m_st == 3));
         chk("m_alarm",  32'(alarm_o),  32'(m_st == 4));
         chk("m_tries",  32'(tries_o),  32'(m_tries));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int md, input bit k, input int kd, input bit s);
      mode = md[1:0]; kv = k; key = kd[DIGIT_W-1:0]; set = s;
      @(posedge clk); #1;
      if (!rst) model_step(md, k, kd, s);
      mode = 2'd0; kv = 1'b0; set = 1'b0;
   endtask

   task automatic code4(input int a, input int b, input int c, input int d);
      cyc(0, 1, a, 0); cyc(0, 1, b, 0); cyc(0, 1, c, 0); cyc(0, 1, d, 0);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_state",  32'(state_o),  32'd0);
      chk("rst_led",    32'(led_o),    32'd3);
      chk("rst_unlock", 32'(unlock_o), 32'd0);
      chk("rst_alarm",  32'(alarm_o),  32'd0);
      chk("rst_tries",  32'(tries_o),  32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int n, md, kd, r;
      bit k, s;
      model_reset();
      do_reset();
      chk_en = 1'b1;

      // Correct default code opens for exactly OPEN_CYCLES clocks.
      cyc(1, 0, 0, 0);
      chk("ent_after_A", 32'(state_o), 32'd1);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
      chk("ent_3keys", 32'(state_o), 32'd1);
      cyc(0, 1, 0, 0);
      chk("open_4th", 32'(state_o), 32'd3);
      chk("unlock_4th", 32'(unlock_o), 32'd1);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 0);
         if (unlock_o) n++;
         else break;
      end
      chk("open_len", 32'(n), 32'(OPEN_CYCLES));
      chk("led_idle", 32'(led_o), 32'd3);

      // Code change to 1234, wrong code bumps tries, right code clears.
      cyc(1, 0, 0, 0); code4(0, 0, 0, 0);
      cyc(2, 0, 0, 0);
      chk("set_state", 32'(state_o), 32'd2);
      chk("set_led", 32'(led_o), 32'd2);
      code4(1, 2, 3, 4);
      cyc(0, 0, 0, 1);
      chk("set_commit", 32'(state_o), 32'd0);
      cyc(1, 0, 0, 0); code4(0, 0, 0, 0);
      chk("old_code_tries", 32'(tries_o), 32'd1);
      chk("old_code_state", 32'(state_o), 32'd1);
      code4(1, 2, 3, 4);
      chk("new_code_open", 32'(state_o), 32'd3);
      chk("new_code_tries", 32'(tries_o), 32'd0);
      cyc(1, 0, 0, 0);

      // Three wrong codes.
      cyc(1, 0, 0, 0);
      code4(5, 5, 5, 5); chk("wrong1", 32'(tries_o), 32'd1);
      code4(5, 5, 5, 5); chk("wrong2", 32'(tries_o), 32'd2);
      code4(5, 5, 5, 5);
`ifdef DOORLOCK_LOCKOUT_EN
      chk("lock_state", 32'(state_o), 32'd4);
      chk("lock_alarm", 32'(alarm_o), 32'd1);
      chk("lock_tries", 32'(tries_o), 32'd3);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         cyc($urandom_range(0, 3), 1'b1, $urandom_range(0, 9), 1'b0);
         if (alarm_o) n++;
         else break;
      end
      chk("lock_len", 32'(n), 32'(LOCK_CYCLES));
      chk("lock_exit_state", 32'(state_o), 32'd0);
      chk("lock_exit_tries", 32'(tries_o), 32'd0);
      cyc(1, 0, 0, 0);
`else
      chk("nolock_state", 32'(state_o), 32'd1);
      chk("nolock_tries", 32'(tries_o), 32'd3);
      code4(5, 5, 5, 5);
      chk("nolock_sat", 32'(tries_o), 32'd3);
      chk("nolock_alarm", 32'(alarm_o), 32'd0);
`endif

      // CLR discards partial entry; CLR beats a simultaneous key.
      cyc(0, 1, 1, 0); cyc(0, 1, 2, 0); cyc(3, 0, 0, 0);
      code4(1, 2, 3, 4);
      chk("clr_open", 32'(state_o), 32'd3);
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      cyc(3, 1, 1, 0);
      cyc(0, 1, 1, 0); cyc(0, 1, 2, 0); cyc(0, 1, 3, 0);
      chk("clrkey_3", 32'(state_o), 32'd1);
      cyc(0, 1, 4, 0);
      chk("clrkey_open", 32'(state_o), 32'd3);

      // Short SET entry returns to OPEN and keeps the stored code.
      cyc(2, 0, 0, 0); cyc(0, 1, 9, 0); cyc(0, 1, 9, 0);
      cyc(0, 0, 0, 1);
      chk("short_set", 32'(state_o), 32'd3);
      chk("short_set_unl", 32'(unlock_o), 32'd1);
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); code4(1, 2, 3, 4);
      chk("code_kept", 32'(state_o), 32'd3);

      // Reset mid-SET restores the default code.
      cyc(2, 0, 0, 0); cyc(0, 1, 7, 0);
      do_reset();
      cyc(1, 0, 0, 0); code4(0, 0, 0, 0);
      chk("code_reset", 32'(state_o), 32'd3);
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      code4(5, 5, 5, 5); code4(5, 5, 5, 5); code4(5, 5, 5, 5);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
`ifdef DOORLOCK_LOCKOUT_EN
      chk("mid_lock", 32'(state_o), 32'd4);
`endif
      do_reset();

      // Randomized traffic; digits drawn mostly from {0,1} so codes match often.
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 999);
         if (r < 3) do_reset();
         else begin
            r  = $urandom_range(0, 19);
            md = (r < 12) ? 0 : (r < 15) ? 1 : (r < 17) ? 2 : 3;
            k  = ($urandom_range(0, 9) < 4);
            kd = ($urandom_range(0, 15) == 0) ? 9 : $urandom_range(0, 1);
            s  = (md == 0 && !k && $urandom_range(0, 9) == 0);
            cyc(md, k, kd, s);
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/doorlock_ctrl.md
# doorlock_ctrl

Parametrised door-lock controller: collects a multi-digit keypad code, compares it to a stored code, and opens the lock for a bounded time. It adds a wrong-attempt counter with a timed lockout, and a code-change mode reached only from the open state. It sits between the keypad scanner (one strobe per digit) and the lock actuator/LED driver, replacing the fixed single-compare FSM.

## Interface
- DIGITS, 4 — code length in digits (≥1)
- DIGIT_W, 4 — bits per digit
- MAX_TRIES, 3 — consecutive wrong codes before lockout (≥1)
- OPEN_CYCLES, 500 — clocks the lock stays open without user action (≥2)
- LOCK_CYCLES, 1000 — lockout duration in clocks (≥2)
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous and active-high
- mode_i  in  2  command: 2'd1 = A (enter/close), 2'd2 = B (set), 2'd3 = CLR (discard digits), 2'd0 = none
- key_valid_i  in  1  one-cycle digit strobe
- key_i  in  DIGIT_W  digit, sampled when key_valid_i = 1
- set_i  in  1  commit new code (SET state only)
- state_o  out  3  current state encoding
- led_sig_o  out  3  LED pattern for current state
- unlock_o  out  1  lock actuator drive, high only in OPEN
- alarm_o  out  1  high only in LOCKOUT
- tries_o  out  $clog2(MAX_TRIES+1)  consecutive wrong attempts

## Operation
- States (state_o / led_sig_o): IDLE 0/3, ENT_CODE 1/0, OPEN 3/1, SET 2/2, LOCKOUT 4/4. led_sig_o, unlock_o and alarm_o are combinational decodes of the state register.
- Stored code register, DIGITS×DIGIT_W bits, resets to all zeros. Digit buffer and digit counter (0..DIGITS) are shared by ENT_CODE and SET.
- IDLE: mode_i = A → ENT_CODE with digit counter cleared. Keys are ignored.
- ENT_CODE: each key_valid_i shifts key_i into the buffer, first digit most significant. On the strobe that makes the count DIGITS, the assembled code (buffer plus current key) is compared with the stored code:
  - Match → OPEN; tries cleared; open timer loaded.
  - Mismatch, tries+1 < MAX_TRIES → stay in ENT_CODE; tries incremented; counter cleared.
  - Mismatch, tries+1 = MAX_TRIES → LOCKOUT; tries = MAX_TRIES; lock timer loaded.
  - mode_i = CLR clears the counter without affecting tries. CLR takes priority over a simultaneous key strobe.
- OPEN: mode_i = A → IDLE (close). mode_i = B → SET with counter cleared. Otherwise the open timer counts down, and expiry → IDLE. A/B take priority over a timer expiry in the same cycle.
- SET: keys fill the buffer, and strobes beyond DIGITS are ignored. set_i with count = DIGITS copies the buffer to the stored code → IDLE. set_i with count < DIGITS discards the buffer → OPEN with a fresh open timer. CLR clears the counter.
- LOCKOUT: all inputs are ignored. Lock timer expiry → IDLE, with tries cleared.
- The tries counter is held across IDLE/ENT_CODE and cleared only by a correct code, lockout expiry, or reset.

## Timing
- All state and register updates happen on the rising clock edge. Outputs change in the cycle after the causing input is sampled.
- Compare latency: the final digit is sampled at edge N, and state_o/unlock_o reflect the result after edge N.
- Open timer: unlock_o is high for exactly OPEN_CYCLES clocks when no command arrives. Lockout: alarm_o is high for exactly LOCK_CYCLES clocks.
- Timer widths are $clog2(max count + 1). Timers never wrap, and reload on every entry.
- Reset, asynchronous and any time including mid-entry or mid-lockout:
  - state = IDLE, stored code = 0, counters and timers = 0.
  - Outputs: state_o = 0, led_sig_o = 3, unlock_o = 0, alarm_o = 0, tries_o = 0.
- Unused state encodings (5–7) → IDLE on the next edge.

## Configuration
- DOORLOCK_LOCKOUT_EN defined: try counting and the LOCKOUT state behave as above.
- DOORLOCK_LOCKOUT_EN undefined:
  - LOCKOUT state and lock timer are not built.
  - A mismatch always stays in ENT_CODE with the counter cleared.
  - tries_o still counts but saturates at MAX_TRIES.
  - alarm_o is tied 0.
  - LOCK_CYCLES is unused.

## Test plan
All scenarios use DIGITS=4, DIGIT_W=4, MAX_TRIES=3, OPEN_CYCLES=8, LOCK_CYCLES=16.
- Reset, A, keys 0,0,0,0 → OPEN after the 4th key edge; unlock_o high for 8 cycles, then IDLE with led_sig_o = 3.
- From OPEN: B, keys 1,2,3,4, set_i → IDLE; then A, keys 0,0,0,0 → tries_o = 1, still ENT_CODE; then keys 1,2,3,4 → OPEN with tries_o = 0.
- Three wrong codes (5,5,5,5) → tries_o 1, 2, then LOCKOUT; alarm_o high 16 cycles with keys ignored; then IDLE with tries_o = 0. Without the macro: stays in ENT_CODE, tries_o saturates at 3, alarm_o = 0.
- ENT_CODE: keys 0,0, CLR, keys 0,0,0,0 → OPEN; CLR with a simultaneous key → count stays 0.
- SET: keys 9,9, set_i → OPEN; stored code still 0000.
- Assert rst_i asynchronously mid-LOCKOUT and mid-SET → all outputs at reset values immediately; stored code returns to 0000.
